// File: rtl/qspi_iob_pkg.sv
// Shared types and constants for the QSPI I/O arbiter: handover states,
// owner encoding and the supported parameter ranges.
package qspi_iob_pkg;

  typedef enum logic [1:0] {
    S_PAD  = 2'd0,
    S_WAIT = 2'd1,
    S_TURN = 2'd2,
    S_SU   = 2'd3
  } state_t;

  localparam logic OWN_PAD = 1'b0;
  localparam logic OWN_SU  = 1'b1;

  localparam int MAX_N_CS        = 4;
  localparam int MAX_LANES       = 4;
  localparam int MAX_SYNC_STAGES = 3;

endpackage

// File: rtl/qspi_pad_bank.sv
// External pad bank: one tri-state I/O buffer per data lane and per chip select.
// Purely combinational; a lane whose buffer is driving still reads its own pad.
module qspi_pad_bank
  import qspi_iob_pkg::*;
#(
  parameter int N_CS  = 1,
  parameter int LANES = 4
) (
  input  logic [N_CS-1:0]  ss_o,
  input  logic [N_CS-1:0]  ss_t,
  input  logic [LANES-1:0] io_o,
  input  logic [LANES-1:0] io_t,
  output logic [LANES-1:0] io_i,
  inout  wire  [N_CS-1:0]  ss,
  inout  wire  [LANES-1:0] io
);

  localparam int CS_USED   = (N_CS < MAX_N_CS) ? N_CS : MAX_N_CS;
  localparam int LANE_USED = (LANES < MAX_LANES) ? LANES : MAX_LANES;

  for (genvar g = 0; g < CS_USED; g++) begin : g_cs
    assign ss[g] = ss_t[g] ? 1'bz : ss_o[g];
  end

  for (genvar g = 0; g < LANE_USED; g++) begin : g_lane
    assign io[g]   = io_t[g] ? 1'bz : io_o[g];
    assign io_i[g] = io[g];
  end

endmodule

// File: rtl/qspi_iob_arb.sv
// Routes one QSPI master to either the external pad bank or the STARTUP flash path,
// switching owners only between transactions with a released-bus turnaround.
module qspi_iob_arb
  import qspi_iob_pkg::*;
#(
  parameter int N_CS        = 1,
  parameter int LANES       = 4,
  parameter int TURN_CYCLES = 4,
  parameter int SYNC_STAGES = 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             sel_req,
  output logic             sel_ack,
  output logic             busy,
  input  logic [N_CS-1:0]  ss_o,
  input  logic             ss_t,
  input  logic [LANES-1:0] io_o,
  input  logic [LANES-1:0] io_t,
  output logic [LANES-1:0] io_i,
  inout  wire  [N_CS-1:0]  ss,
  inout  wire  [LANES-1:0] io,
  output logic             su_cs_n,
  output logic [LANES-1:0] su_dq_o,
  output logic [LANES-1:0] su_dq_t,
  input  logic [LANES-1:0] su_dq_i,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
  localparam int SYNC_N = (SYNC_STAGES > MAX_SYNC_STAGES) ? MAX_SYNC_STAGES : SYNC_STAGES;

  state_t           r_state;
  state_t           w_state_nxt;
  state_t           w_home;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_owner;
  logic             w_owner_nxt;

  logic             w_idle;
  logic             w_switch;
  logic             w_turn;
  logic             w_pad_act;
  logic             w_su_act;
  logic [N_CS-1:0]  w_pad_ss_t;
  logic [LANES-1:0] w_pad_io_t;
  logic [LANES-1:0] w_pad_io_i;
  logic [LANES-1:0] w_ret;
  logic [LANES-1:0] w_pipe_out;

  // sel_req/sel_ack is a level handshake: sel_req may change at any time, sel_ack
  // follows only after the master goes idle and the turnaround elapses; busy marks the gap.
  assign w_idle   = (&ss_o) | ss_t;
  assign w_switch = (sel_req != r_owner);
  assign w_home   = (r_owner == OWN_SU) ? S_SU : S_PAD;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_PAD;
      r_cnt   <= '0;
      r_owner <= OWN_PAD;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_owner_nxt = r_owner;
    unique case (r_state)
      S_PAD, S_SU: begin
        if (w_switch) begin
          if (w_idle) begin
            w_state_nxt = S_TURN;
            w_cnt_nxt   = TURN_LOAD;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!w_switch) begin
          w_state_nxt = w_home;
        end else if (w_idle) begin
          w_state_nxt = S_TURN;
          w_cnt_nxt   = TURN_LOAD;
        end
      end
      S_TURN: begin
        // The request is sampled only on the final turnaround clock; earlier toggles are ignored.
        if (r_cnt == '0) begin
          w_owner_nxt = sel_req;
          w_state_nxt = sel_req ? S_SU : S_PAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = S_PAD;
    endcase
  end

  // Drivers are gated by aresetn so they release the instant reset asserts.
  assign w_turn    = (r_state == S_TURN);
  assign w_pad_act = aresetn & ~w_turn & (r_owner == OWN_PAD);
  assign w_su_act  = aresetn & ~w_turn & (r_owner == OWN_SU);

  assign w_pad_io_t = w_pad_act ? io_t : '1;
  assign w_pad_ss_t = {N_CS{~(w_pad_act & ~ss_t)}};

  qspi_pad_bank #(
    .N_CS  (N_CS),
    .LANES (LANES)
  ) u_pad_bank (
    .ss_o (ss_o),
    .ss_t (w_pad_ss_t),
    .io_o (io_o),
    .io_t (w_pad_io_t),
    .io_i (w_pad_io_i),
    .ss   (ss),
    .io   (io)
  );

  assign su_cs_n = w_su_act ? ss_o[0] : 1'b1;
  assign su_dq_o = io_o;
  assign su_dq_t = w_su_act ? io_t : '1;

  assign w_ret = (w_turn | ~aresetn) ? '0 :
                 ((r_owner == OWN_SU) ? su_dq_i : w_pad_io_i);

  if (SYNC_N == 0) begin : g_comb
    assign w_pipe_out = w_ret;
  end else begin : g_sync
    logic [LANES-1:0] r_pipe [SYNC_N];

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        for (int k = 0; k < SYNC_N; k++) r_pipe[k] <= '0;
      end else begin
        r_pipe[0] <= w_ret;
        for (int k = 1; k < SYNC_N; k++) r_pipe[k] <= r_pipe[k-1];
      end
    end

    assign w_pipe_out = r_pipe[SYNC_N-1];
  end

  assign io_i      = w_turn ? '0 : w_pipe_out;
  assign sel_ack   = r_owner;
  assign busy      = (r_state == S_WAIT) | w_turn;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_qspi_iob_arb.sv
// Directed and randomized bench for qspi_iob_arb, checked against a behavioural
// model of ownership, turnaround timing and the read-data delay line.
module tb_qspi_iob_arb;

  localparam int N_CS  = 2;
  localparam int LANES = 4;
  localparam int TURN  = 4;
  localparam int SYNC  = 2;

  logic             aclk    = 1'b0;
  logic             aresetn = 1'b0;
  logic             sel_req = 1'b0;
  logic             ss_t    = 1'b0;
  logic [N_CS-1:0]  ss_o    = '1;
  logic [LANES-1:0] io_o    = '0;
  logic [LANES-1:0] io_t    = '1;
  logic [LANES-1:0] su_dq_i = '0;

  logic             sel_ack, busy, su_cs_n;
  logic [LANES-1:0] io_i, su_dq_o, su_dq_t;
  logic [1:0]       dbg_state;
  wire  [N_CS-1:0]  ss;
  wire  [LANES-1:0] io;

  for (genvar g = 0; g < LANES; g++) begin : g_pu_io
    pullup (io[g]);
  end
  for (genvar g = 0; g < N_CS; g++) begin : g_pu_ss
    pullup (ss[g]);
  end

  always #5 aclk = ~aclk;

  qspi_iob_arb #(
    .N_CS        (N_CS),
    .LANES       (LANES),
    .TURN_CYCLES (TURN),
    .SYNC_STAGES (SYNC)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .sel_req   (sel_req),
    .sel_ack   (sel_ack),
    .busy      (busy),
    .ss_o      (ss_o),
    .ss_t      (ss_t),
    .io_o      (io_o),
    .io_t      (io_t),
    .io_i      (io_i),
    .ss        (ss),
    .io        (io),
    .su_cs_n   (su_cs_n),
    .su_dq_o   (su_dq_o),
    .su_dq_t   (su_dq_t),
    .su_dq_i   (su_dq_i),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: current owner, whether a request is pending, clocks left in the turnaround.
  logic             m_owner;
  logic             m_wait;
  int               m_turn_left;
  logic [LANES-1:0] exp_q[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner     = 1'b0;
    m_wait      = 1'b0;
    m_turn_left = 0;
    exp_q.delete();
    for (int k = 0; k < SYNC; k++) exp_q.push_back('0);
  endtask

  function automatic logic pad_on();
    return aresetn && (m_turn_left == 0) && (m_owner == 1'b0);
  endfunction

  function automatic logic su_on();
    return aresetn && (m_turn_left == 0) && (m_owner == 1'b1);
  endfunction

  // Pad lanes read back what the buffer drives, or the pull-up when released.
  function automatic logic [LANES-1:0] pad_expect(logic on);
    logic [LANES-1:0] v;
    for (int l = 0; l < LANES; l++) v[l] = (on && !io_t[l]) ? io_o[l] : 1'b1;
    return v;
  endfunction

  task automatic model_clock();
    logic [LANES-1:0] ret;
    logic             idle;
    if (!aresetn) return;
    if (m_turn_left != 0) ret = '0;
    else if (m_owner)     ret = su_dq_i;
    else                  ret = pad_expect(1'b1);
    exp_q.push_back(ret);
    void'(exp_q.pop_front());
    idle = (&ss_o) || ss_t;
    if (m_turn_left != 0) begin
      if (m_turn_left == 1) begin
        m_owner     = sel_req;
        m_turn_left = 0;
      end else begin
        m_turn_left = m_turn_left - 1;
      end
    end else if (sel_req != m_owner) begin
      if (idle) begin
        m_turn_left = TURN;
        m_wait      = 1'b0;
      end else begin
        m_wait = 1'b1;
      end
    end else begin
      m_wait = 1'b0;
    end
  endtask

  task automatic check_outputs(string tag);
    logic turning;
    turning = (m_turn_left != 0);
    chk({tag, ".sel_ack"}, 32'(sel_ack), 32'(m_owner));
    chk({tag, ".busy"}, 32'(busy), 32'(m_wait || turning));
    chk({tag, ".io_i"}, 32'(io_i), (turning || !aresetn) ? 32'd0 : 32'(exp_q[0]));
    chk({tag, ".su_cs_n"}, 32'(su_cs_n), su_on() ? 32'(ss_o[0]) : 32'd1);
    chk({tag, ".su_dq_t"}, 32'(su_dq_t), su_on() ? 32'(io_t) : 32'hF);
    if (su_on()) chk({tag, ".su_dq_o"}, 32'(su_dq_o), 32'(io_o));
    chk({tag, ".io_pad"}, 32'(io), 32'(pad_expect(pad_on())));
    chk({tag, ".ss_pad"}, 32'(ss), (pad_on() && !ss_t) ? 32'(ss_o) : 32'h3);
  endtask

  task automatic step_check(string tag);
    @(posedge aclk);
    model_clock();
    @(negedge aclk);
    check_outputs(tag);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_len;
    model_reset();
    repeat (3) @(negedge aclk);
    check_outputs("reset");
    aresetn = 1'b1;
    step_check("idle");
    step_check("idle");

    // Idle handover to STARTUP: request and idle bus in the same cycle.
    io_o = 4'hA; io_t = 4'h0; sel_req = 1'b1;
    busy_len = 0;
    for (int i = 0; i < 12; i++) begin
      step_check("ho_su");
      if (busy) busy_len++;
      else break;
    end
    chk("ho_su.turn_len", 32'(busy_len), 32'(TURN));
    chk("ho_su.ack", 32'(sel_ack), 32'd1);
    chk("ho_su.su_dq_o", 32'(su_dq_o), 32'hA);

    // Return path delay from the STARTUP input.
    io_t = 4'hF; su_dq_i = 4'h3;
    step_check("ret1");
    chk("ret.lat1", 32'(io_i), 32'd0);
    step_check("ret2");
    chk("ret.lat2", 32'(io_i), 32'h3);

    // Only ss_o[0] reaches STARTUP; pad selects stay released.
    ss_o = 2'b00;
    step_check("su_cs");
    chk("su_cs.ss_pad", 32'(ss), 32'h3);
    ss_o = 2'b11;

    // Hand back to the pad with a request glitch inside the turnaround.
    su_dq_i = 4'h5; sel_req = 1'b0;
    step_check("hb");
    step_check("hb");
    sel_req = 1'b1;
    step_check("hb_glitch");
    sel_req = 1'b0;
    step_check("hb");
    step_check("hb");
    step_check("hb");
    chk("hb.ack", 32'(sel_ack), 32'd0);

    // Request cancelled while the master is mid-transaction.
    ss_o = 2'b10; io_o = 4'h5; io_t = 4'h0; sel_req = 1'b1;
    repeat (3) step_check("cancel_wait");
    chk("cancel.busy_wait", 32'(busy), 32'd1);
    sel_req = 1'b0;
    step_check("cancel");
    chk("cancel.busy", 32'(busy), 32'd0);
    chk("cancel.ack", 32'(sel_ack), 32'd0);

    // Handover requested mid-transaction waits for chip select release.
    sel_req = 1'b1;
    repeat (20) step_check("mid_wait");
    chk("mid.io", 32'(io), 32'h5);
    ss_o = 2'b11;
    step_check("mid_turn");
    chk("mid.turn_io_i", 32'(io_i), 32'd0);
    repeat (TURN) step_check("mid_turn");
    chk("mid.ack", 32'(sel_ack), 32'd1);

    // Asynchronous reset in the second turnaround clock.
    sel_req = 1'b0;
    step_check("rst_turn");
    step_check("rst_turn");
    aresetn = 1'b0;
    model_reset();
    #1;
    check_outputs("rst_async");
    chk("rst_async.su_dq_t", 32'(su_dq_t), 32'hF);
    @(negedge aclk);
    check_outputs("rst_hold");
    aresetn = 1'b1;
    step_check("rst_after");
    chk("rst_after.ack", 32'(sel_ack), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) sel_req = ~sel_req;
      ss_t    = ($urandom_range(0, 9) == 0);
      ss_o    = ($urandom_range(0, 2) == 0) ? 2'b11 : 2'($urandom_range(0, 3));
      io_o    = 4'($urandom);
      io_t    = 4'($urandom);
      su_dq_i = 4'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        aresetn = 1'b0;
        model_reset();
        #1;
        check_outputs("rnd_rst");
        @(negedge aclk);
        aresetn = 1'b1;
      end
      step_check("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qspi_iob_arb.md
Name: qspi_iob_arb

Overview:
- Parametrised QSPI I/O block for the static region.
- Routes one QSPI master (quad-SPI controller, ss/io with _o/_t/_i triplets) to one of two flash paths:
  - the external pad bank, through IOBUFs;
  - the configuration-flash path exposed by the STARTUP primitive.
- Path ownership changes only between transactions. A chip-select-aware handover FSM inserts a tri-state turnaround.
- Returned read data passes through a configurable sampling pipeline.

Parameters:
- N_CS, 1, number of chip selects (1..4).
- LANES, 4, number of data lanes (1, 2 or 4).
- TURN_CYCLES, 4, clocks with all drivers released during a handover (>=1).
- SYNC_STAGES, 1, register stages on the returned read data (0..3; 0 = combinational).

Ports:
- aclk  in  1  block clock.
- aresetn  in  1  asynchronous active-low reset.
- sel_req  in  1  requested owner: 0 = pad bank, 1 = STARTUP path.
- sel_ack  out  1  current owner; equals sel_req once the handover completes.
- busy  out  1  handover pending or in turnaround.
- ss_o  in  N_CS  master chip selects, active low.
- ss_t  in  1  master chip-select tri-state; 1 = released.
- io_o  in  LANES  master data out.
- io_t  in  LANES  master per-lane tri-state; 1 = input.
- io_i  out  LANES  data returned to the master.
- ss  inout  N_CS  pad chip selects.
- io  inout  LANES  pad data lanes.
- su_cs_n  out  1  STARTUP chip select (driven from ss_o[0]).
- su_dq_o  out  LANES  STARTUP data out.
- su_dq_t  out  LANES  STARTUP data tri-state.
- su_dq_i  in  LANES  STARTUP data in.

Behaviour:
- Reset values (aresetn low, asynchronous):
  - FSM in S_PAD; sel_ack=0; busy=0.
  - Turnaround counter 0; sampling registers 0; io_i=0.
- Forward path (io_o/io_t/ss_o to the owner) is combinational, zero latency.
- Non-owner outputs while in the PAD or SU state:
  - pad bank: all _t=1, ss released;
  - STARTUP path: su_dq_t all 1, su_cs_n=1.
- Pad chip-select output enable follows ss_t. ss_t has no effect on su_cs_n.
- idle = (ss_o all ones) or ss_t=1.
- FSM states: S_PAD, S_WAIT, S_TURN, S_SU.
  - S_PAD / S_SU, owner stable:
    - sel_req != sel_ack and idle: go to S_TURN, load counter with TURN_CYCLES-1.
    - sel_req != sel_ack and not idle: go to S_WAIT.
  - S_WAIT:
    - current owner keeps the bus; busy=1.
    - idle: go to S_TURN.
    - sel_req returns to equal sel_ack: go back to the stable state, busy=0.
  - S_TURN:
    - both paths released: all _t=1, all chip selects released, su_cs_n=1; io_i forced to 0; busy=1.
    - counter decrements each clock.
    - at 0, take the owner from sel_req as sampled in that cycle (owner may stay unchanged), go to the matching stable state, update sel_ack in the same edge.
    - sel_req toggling mid-turnaround does not restart or abort the count.
- Master activity during S_TURN is ignored; it is not buffered.
- Return path:
  - io_i = owner's input, delayed SYNC_STAGES clocks.
  - Pad input lanes whose io_t=0 still sample the pad (loopback), as the IOBUF does.
- Simultaneous events:
  - idle and a new request in the same cycle: go directly to S_TURN, skipping S_WAIT.
  - Reset during S_TURN: returns to S_PAD immediately; outputs are released asynchronously.
- LANES<4: unused upper lanes are not instantiated.
- N_CS>1 with the STARTUP path: only ss_o[0] is forwarded; other selects are held released while owner=1.

Decomposition:
- Package qspi_iob_pkg:
  - state enum (S_PAD, S_WAIT, S_TURN, S_SU);
  - owner constants OWN_PAD=0, OWN_SU=1;
  - max-parameter localparams.
- Sub-module qspi_pad_bank (N_CS, LANES): IOBUF per lane and per chip select; no state.
- FSM, counter, muxing and sampling pipeline live in the top.

Test Plan:
- Reset, then idle master (ss_o=1): pad _t all 1, su_cs_n=1, sel_ack=0, busy=0, io_i=0.
- Handover while idle: sel_req 0->1 with ss_o=1 -> busy rises next clock, stays high exactly TURN_CYCLES=4 clocks, then sel_ack=1; su_dq_o follows io_o=4'hA immediately after.
- Handover mid-transaction: sel_req=1 while ss_o=0 for 20 clocks -> pad keeps driving io_o=4'h5 throughout; turnaround starts the clock after ss_o returns to 1.
- Cancelled request: sel_req 0->1->0 during S_WAIT -> no turnaround, sel_ack stays 0, busy clears.
- Return path with SYNC_STAGES=2: su_dq_i steps 0->4'h3 -> io_i reads 4'h3 two clocks later; while in S_TURN, io_i=0.
- Async reset asserted in S_TURN cycle 2 -> all pad/STARTUP outputs released at once; after release sel_ack=0, pad owns the bus.
